// File: rtl/redas_array_ctrl.sv
// redas_array_ctrl
// Job sequencer for a ROWS x COLS grid of REDAS processing elements.
// Each job has four phases:
//   1. Latch the PE configuration when the job starts.
//   2. Load one stationary operand row per accepted wt beat.
//   3. Stream cfg_len activation vectors.
//   4. Drain the array pipeline, then pulse done.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, abort                   job request (IDLE only) / cancel job
//   cfg_mode, cfg_pattern,
//   cfg_right_angle, cfg_len       job configuration, latched on start
//   wt_valid / wt_ready, wt_row    stationary row handshake and row index
//   act_valid / act_ready          activation vector handshake
//   pe_*                           shared PE control lines
//   pe_store_stationary            one-hot per-row stationary strobe
//   out_valid                      result vector valid at array bottom edge
//   busy, done                     job in progress / one-cycle completion pulse
module redas_array_ctrl #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int PE_LAT = 2,
   parameter int LEN_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [3:0]               cfg_mode,
   input  logic [4:0]               cfg_pattern,
   input  logic                     cfg_right_angle,
   input  logic [LEN_W-1:0]         cfg_len,
   input  logic                     wt_valid,
   output logic                     wt_ready,
   output logic [$clog2(ROWS)-1:0]  wt_row,
   input  logic                     act_valid,
   output logic                     act_ready,
   output logic [3:0]               pe_data_movement_mode,
   output logic [4:0]               pe_calculation_pattern_mode,
   output logic                     pe_enable_right_angle_movement,
   output logic [ROWS-1:0]          pe_store_stationary,
   output logic                     out_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int ROW_W = $clog2(ROWS);
   // Latency from an accepted activation to its result leaving the array.
   localparam int FILL = PE_LAT * (ROWS + COLS - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_SETTLE = 3'd2,
      S_STREAM = 3'd3,
      S_DRAIN  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [ROW_W-1:0]  row_r;
   logic [LEN_W-1:0]  cnt_r, len_r;
   logic [3:0]        mode_r;
   logic [4:0]        pat_r;
   logic              ra_r;
   logic [ROWS-1:0]   store_r;
   logic [FILL-1:0]   dly_r;
   logic              wt_ready_r, act_ready_r, busy_r, done_r;

   logic              start_s, abort_s, wt_acc_s, act_acc_s, last_beat_s;
   logic [ROWS-1:0]   row_onehot_s;

   assign start_s      = (state_r == S_IDLE) && start && !abort;
   assign abort_s      = (state_r != S_IDLE) && abort;
   assign wt_acc_s     = (state_r == S_LOAD) && wt_valid;
   assign act_acc_s    = (state_r == S_STREAM) && act_valid;
   // One bit wider so the compare stays exact even at the maximum cfg_len.
   assign last_beat_s  = ({1'b0, cnt_r} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, len_r};
   assign row_onehot_s = {{(ROWS-1){1'b0}}, 1'b1} << row_r;

   // Next-state selection; abort overrides every active state.
   always_comb begin
      state_s = state_r;
      if (abort_s) begin
         state_s = S_IDLE;
      end else begin
         case (state_r)
            S_IDLE:   state_s = start_s ? S_LOAD : S_IDLE;
            S_LOAD:   state_s = (wt_acc_s && (row_r == LAST_ROW)) ? S_SETTLE : S_LOAD;
            S_SETTLE: state_s = (len_r == {LEN_W{1'b0}}) ? S_DRAIN : S_STREAM;
            S_STREAM: state_s = (act_acc_s && last_beat_s) ? S_DRAIN : S_STREAM;
            S_DRAIN:  state_s = (dly_r == {FILL{1'b0}}) ? S_DONE : S_DRAIN;
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
         endcase
      end
   end

   // State, counters, config latch, delay line and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         row_r       <= {ROW_W{1'b0}};
         cnt_r       <= {LEN_W{1'b0}};
         len_r       <= {LEN_W{1'b0}};
         mode_r      <= 4'd0;
         pat_r       <= 5'd0;
         ra_r        <= 1'b0;
         store_r     <= {ROWS{1'b0}};
         dly_r       <= {FILL{1'b0}};
         wt_ready_r  <= 1'b0;
         act_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= state_s;
         if (start_s) begin
            mode_r <= cfg_mode;
            pat_r  <= cfg_pattern;
            ra_r   <= cfg_right_angle;
            len_r  <= cfg_len;
            row_r  <= {ROW_W{1'b0}};
            cnt_r  <= {LEN_W{1'b0}};
         end else begin
            if (wt_acc_s) begin
               row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
            end
            if (act_acc_s) begin
               cnt_r <= cnt_r + {{(LEN_W-1){1'b0}}, 1'b1};
            end
         end
         // The strobe for a row fires the cycle after its beat is accepted.
         store_r <= (wt_acc_s && !abort_s) ? row_onehot_s : {ROWS{1'b0}};
         // Accepted activations march through FILL stages; an abort flushes them.
         dly_r <= abort_s ? {FILL{1'b0}} : {dly_r[FILL-2:0], act_acc_s};
         wt_ready_r  <= (state_s == S_LOAD);
         act_ready_r <= (state_s == S_STREAM);
         busy_r      <= (state_s != S_IDLE);
         done_r      <= (state_s == S_DONE);
      end
   end

   assign wt_ready                       = wt_ready_r;
   assign wt_row                         = row_r;
   assign act_ready                      = act_ready_r;
   assign pe_data_movement_mode          = mode_r;
   assign pe_calculation_pattern_mode    = pat_r;
   assign pe_enable_right_angle_movement = ra_r;
   assign pe_store_stationary            = store_r;
   assign out_valid                      = dly_r[FILL-1];
   assign busy                           = busy_r;
   assign done                           = done_r;

endmodule
